// File: rtl/median_pkg.sv
// Shared types and elaboration helpers for the median output buffer.
// Used by the interface, the FIFO and the top.
package median_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Number of filter outputs produced before the window is full.
    function automatic int skip_len(input int window, input int latency);
        return window - 1 + latency;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/median_out_if.sv
// Valid/ready output channel of the median buffer.
// master drives data/valid, slave drives ready.
interface median_out_if
    import median_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/median_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head.
// A write into an empty (or draining) FIFO is bypassed into the head.
module median_sync_fifo
    import median_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [clog2(DEPTH):0]    level,
    output logic                     full
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;

    logic             w_full;
    logic             w_wr;
    logic             w_rd;
    logic             w_load;
    logic [AW-1:0]    w_rptr_nxt;
    logic [LW-1:0]    w_level_nxt;
    logic [WIDTH-1:0] w_head;

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_rd        = pop & r_valid;
    assign w_wr        = push & (~w_full | w_rd);
    assign w_rptr_nxt  = r_rptr + AW'(w_rd);
    assign w_level_nxt = r_level + LW'(w_wr) - LW'(w_rd);
    assign w_head      = (w_wr && (r_wptr == w_rptr_nxt)) ? din
                                                          : r_mem[w_rptr_nxt];
    // Head only reloads when consumed or empty, so a stalled head holds.
    assign w_load      = w_rd | ~r_valid;

    // Storage array; contents are don't-care after reset or clr.
    always_ff @(posedge clk) begin
        if (w_wr && !clr) r_mem[r_wptr] <= din;
    end

    // Pointers, occupancy and registered show-ahead head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_wr);
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
            if (w_load && (w_level_nxt != '0)) r_dout <= w_head;
        end
    end

    assign dout  = r_dout;
    assign valid = r_valid;
    assign level = r_level;
    assign full  = w_full;
endmodule

// File: rtl/median_out_buffer.sv
// Median filter output stage: drops warm-up samples, buffers the rest
// and reports samples lost to consumer back-pressure.
module median_out_buffer
    import median_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int WINDOW  = 9,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      median_in,
    input  logic                  clr,
    median_out_if.master          m_out,
    output logic [clog2(DEPTH):0] level,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);
    localparam int SKIP = skip_len(WINDOW, LATENCY);
    localparam int CW   = (clog2(SKIP + 1) < 1) ? 1 : clog2(SKIP + 1);
    localparam state_t ST0 = (SKIP == 0) ? RUN : WARMUP;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_valid;
    logic             w_drop;
    logic [WIDTH-1:0] w_dout;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    // Warm-up state and edge counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: discard SKIP samples, then push every clock.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        if (clr) begin
            w_state_nxt = ST0;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                WARMUP: begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CW'(SKIP - 1)) w_state_nxt = RUN;
                end
                RUN: w_push = 1'b1;
            endcase
        end
    end

    assign w_pop  = w_valid & m_out.out_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    median_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (median_in),
        .dout  (w_dout),
        .valid (w_valid),
        .level (level),
        .full  (w_full)
    );

    // Sticky loss flag and saturating loss counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign m_out.out_data  = w_dout;
    assign m_out.out_valid = w_valid;
    assign overflow        = r_overflow;
    assign drop_cnt        = r_drop_cnt;
endmodule

// File: doc/median_out_buffer.md
Name: median_out_buffer

Overview:
- Downstream stage of the median filter top. It consumes the 16-bit median stream, which the filter produces at one sample per clock.
- Discards the warm-up outputs produced while the filter window is still filling after reset.
- Buffers the valid medians in a small FIFO and presents them over a valid/ready interface to the consumer.
- Flags and counts samples lost when the consumer stalls longer than the FIFO can absorb.

Parameters:
- WIDTH, 16: sample width; must equal the filter output width.
- WINDOW, 9: median window length of the upstream filter; must be at least 1.
- LATENCY, 2: pipeline latency of the upstream filter in clocks, input to median.
- DEPTH, 8: FIFO depth; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- median_in  in  WIDTH  median sample from the filter, one per clock.
- clr  in  1  synchronous restart: flush the FIFO, restart warm-up, clear flags.
- out_data  out  WIDTH  head-of-FIFO sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a valid sample was dropped.
- drop_cnt  out  8  count of dropped samples; saturates at 255.

Behaviour:
- Reset values, applied immediately on reset with no clock needed:
  - out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0.
  - FSM in WARMUP; warm-up counter at 0; read and write pointers at 0.
- SKIP = WINDOW-1+LATENCY, computed at elaboration.
- FSM WARMUP:
  - Counts rising edges after reset is released.
  - Edges 0..SKIP-1 sample median_in and discard it.
  - At edge SKIP-1 the FSM moves to RUN.
  - If SKIP=0, the FSM leaves reset directly in RUN.
- FSM RUN:
  - Every edge is a push of median_in.
  - RUN is left only by reset or clr.
- Push:
  - Writes the memory at the write pointer and increments the write pointer (wraps modulo DEPTH).
  - Increments level.
- Pop:
  - Occurs when out_valid && out_ready.
  - Increments the read pointer (wraps) and decrements level.
- out_data and out_valid are registered show-ahead outputs:
  - A sample pushed into an empty FIFO appears with out_valid=1 one clock after its push edge.
  - Pointers must not disturb out_data while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - This includes level=DEPTH: no drop.
  - It also includes level=1, where the next sample streams through with out_valid held high.
- Push while full with no pop in the same cycle:
  - The sample is dropped and FIFO contents are unchanged.
  - overflow is set to 1.
  - drop_cnt increments, saturating at 255.
- clr, synchronous:
  - Has priority over push and pop.
  - Pointers reset to 0, level=0, out_valid=0 after the edge, overflow=0, drop_cnt=0.
  - FSM returns to WARMUP with the counter at 0. The clr edge itself is not counted, so the next SKIP edges are discarded.
- Reset asserted mid-operation: all state returns to reset values asynchronously; in-flight data is lost.
- level never exceeds DEPTH; drop_cnt never wraps.

Decomposition:
- Package median_pkg holds:
  - DATA_W=16.
  - FSM state typedef {WARMUP, RUN}.
  - Constant function for SKIP.
  - clog2 helper.
- One sub-module, median_sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports: push, pop, din, dout, valid, level, full.
  - Handles show-ahead, wrap, simultaneous push/pop.
- The top block holds the warm-up FSM, drop logic and counters.

Test Plan:
- Warm-up with defaults, out_ready=1, median_in=k on edge k after reset release:
  - out_valid first high after edge 10 with out_data=10.
  - Then 11, 12, ... one per clock, level stays ≤1.
- Stall: out_ready=0 from edge 10:
  - Samples 10..17 stored, level=8.
  - Edge 18 drops 18: overflow=1, drop_cnt=1.
  - Then raise out_ready and hold median_in at 0, pushing a 0 on every edge while draining: out_data sequence is 10..17 with no gap, followed by the pushed 0s, and level stays 8 during the drain.
- Full plus pop: level=8 with out_ready=1 on the same edge as a push: level stays 8, overflow stays 0, order preserved.
- Saturation: out_ready=0 for 300 RUN cycles: drop_cnt=255 and held, level=8.
- clr mid-run at level=5: next cycle out_valid=0, level=0, overflow=0; the following 10 samples are discarded and the 11th (k=clr edge+11) is the first output.
- Async reset and parameters:
  - Assert reset between clock edges during RUN: out_valid and level go to 0 before the next edge.
  - Rerun the warm-up test with WINDOW=3, LATENCY=0: first output is sample 2.
